spi_slave_reg_bridge: RTL and testbench

//   SPI slave front end for the host (STM) link. It deserialises host SPI frames into

---
 rtl/spi_slave_reg_bridge_if.sv | 18 +
 rtl/spi_slave_reg_bridge.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_reg_bridge.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_reg_bridge_if.sv
// Register-bus interface between the SPI slave bridge and the register bank.
// master: the bridge (drives address/data/strobes), slave: the register bank.
interface spi_slave_reg_bridge_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport master (output bus_addr, bus_wdata, bus_we, bus_re,
                    input  bus_rdata, bus_rvalid);
    modport slave  (input  bus_addr, bus_wdata, bus_we, bus_re,
                    output bus_rdata, bus_rvalid);
endinterface

// File: rtl/spi_slave_reg_bridge.sv
// SPI slave (CPOL=0) to register-bus bridge. SPI pins are oversampled in sys_clk.
// Frame: R/~W, ADDR_W address bits MSB first, DUMMY_CYCLES turnaround clocks,
// DATA_W data bits MSB first. Reads return bank data on MISO, writes pulse bus_we.
// Optional macro SPI_BRIDGE_ERRCNT_EN builds a saturating frame-error counter
// (aborted frames and late reads); without it err_count is tied to zero.
module spi_slave_reg_bridge #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 16,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   spi_clk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   spi_miso_oe,
    spi_slave_reg_bridge_if.master bus,
    output logic [7:0]             err_count
);
    localparam int MAXN  = (DATA_W > ADDR_W) ? ((DATA_W > DUMMY_CYCLES) ? DATA_W : DUMMY_CYCLES)
                                             : ((ADDR_W > DUMMY_CYCLES) ? ADDR_W : DUMMY_CYCLES);
    localparam int CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DUMMY_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

    state_t            state;
    logic [1:0]        clk_s, cs_s, mosi_s;
    logic              clk_d, cs_d, armed;
    logic [CNT_W-1:0]  cnt;
    logic              rnw;
    logic [ADDR_W-2:0] addr_sr;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              rd_pend, rd_have;
    logic [DATA_W-1:0] rd_data;

    wire rise    = clk_s[1] & ~clk_d;
    wire fall    = ~clk_s[1] & clk_d;
    wire cs_fall = cs_d & ~cs_s[1];
    wire cs_rise = ~cs_d & cs_s[1];
    wire mosi    = mosi_s[1];
    // A read window is open from the bus_re cycle onward; data arriving in the
    // same cycle as DATA entry is forwarded straight into the TX word.
    wire rd_open = rd_pend | bus.bus_re;
    wire rd_fwd  = rd_open & bus.bus_rvalid;
    wire rd_ok   = rd_have | rd_fwd;
    wire [DATA_W-1:0] tx_word = rd_have ? rd_data : (rd_fwd ? bus.bus_rdata : '0);

    // Pin synchronisers and edge-detect history. CS sync resets to "active" so
    // a frame already in flight when reset releases is never mistaken for a new
    // cs_n fall; armed records that CS has been seen high since reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_s  <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
            clk_d  <= 1'b0;
            cs_d   <= 1'b0;
            armed  <= 1'b0;
        end else begin
            clk_s  <= {clk_s[0], spi_clk};
            cs_s   <= {cs_s[0], spi_cs_n};
            mosi_s <= {mosi_s[0], spi_mosi};
            clk_d  <= clk_s[1];
            cs_d   <= cs_s[1];
            armed  <= armed | cs_s[1];
        end
    end

    // Frame FSM with registered strobes, address/data capture and MISO shifting.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rnw           <= 1'b0;
            addr_sr       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            spi_miso      <= 1'b0;
            spi_miso_oe   <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_we    <= 1'b0;
            bus.bus_re    <= 1'b0;
        end else begin
            bus.bus_we  <= 1'b0;
            bus.bus_re  <= 1'b0;
            spi_miso_oe <= ~cs_s[1] & armed;
            if (cs_rise) begin
                // End of frame, or abort when it arrives before DONE.
                state    <= IDLE;
                cnt      <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        cnt      <= '0;
                        if (cs_fall) state <= CMD;
                    end
                    CMD: if (rise) begin
                        rnw   <= mosi;
                        state <= ADDR;
                    end
                    ADDR: if (rise) begin
                        addr_sr <= {addr_sr[ADDR_W-3:0], mosi};
                        if (cnt == A_LAST) begin
                            bus.bus_addr <= {addr_sr, mosi};
                            bus.bus_re   <= rnw;
                            cnt          <= '0;
                            state        <= DUMMY;
                        end else cnt <= cnt + 1'b1;
                    end
                    DUMMY: if (rise) begin
                        if (cnt == D_LAST) begin
                            tx_sr <= rnw ? tx_word : '0;
                            cnt   <= '0;
                            state <= DATA;
                        end else cnt <= cnt + 1'b1;
                    end
                    DATA: begin
                        if (fall) begin
                            spi_miso <= tx_sr[DATA_W-1];
                            tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                        if (rise) begin
                            rx_sr <= {rx_sr[DATA_W-3:0], mosi};
                            if (cnt == W_LAST) begin
                                if (!rnw) begin
                                    bus.bus_we    <= 1'b1;
                                    bus.bus_wdata <= {rx_sr, mosi};
                                end
                                state <= DONE;
                            end else cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;  // DONE: extra clocks ignored until cs_n rises
                endcase
            end
        end
    end

    // Capture the first bank response after bus_re, up to DATA entry.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_pend <= 1'b0;
            rd_have <= 1'b0;
            rd_data <= '0;
        end else if (cs_fall) begin
            rd_pend <= 1'b0;
            rd_have <= 1'b0;
        end else begin
            if (bus.bus_re) rd_pend <= 1'b1;
            if (state == DUMMY && rd_fwd && !rd_have) begin
                rd_have <= 1'b1;
                rd_data <= bus.bus_rdata;
            end
        end
    end

`ifdef SPI_BRIDGE_ERRCNT_EN
    logic frame_err;
    wire  abort_evt = cs_rise && (state inside {CMD, ADDR, DUMMY, DATA});
    wire  late_evt  = rise && state == DUMMY && cnt == D_LAST && rnw && !rd_ok;

    // Count at most one error per frame (abort and late read together count once).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_err <= 1'b0;
            err_count <= 8'h00;
        end else if (cs_fall) begin
            frame_err <= 1'b0;
        end else if ((abort_evt || late_evt) && !frame_err) begin
            frame_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'h01;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Directed bench for spi_slave_reg_bridge: host SPI frames driven by task,
// a small register-bank model, and immediate-assertion checks.
module tb_spi_slave_reg_bridge;
    localparam int HALF = 50;  // SPI half period (sys_clk is 10 ns)
`ifdef SPI_BRIDGE_ERRCNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] err_count;

    always #5 sys_clk = ~sys_clk;

    spi_slave_reg_bridge_if #(.ADDR_W(7), .DATA_W(16)) bif ();

    spi_slave_reg_bridge #(.ADDR_W(7), .DATA_W(16), .DUMMY_CYCLES(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .bus(bif), .err_count(err_count)
    );

    // Register bank model: rvalid two cycles after bus_re, data from a fixed
    // word or from a small memory written by bus_we.
    logic        bank_en = 1'b1;
    logic        bank_mem = 1'b0;
    logic [15:0] bank_data = 16'h0000;
    logic [15:0] mem [0:127];
    logic [1:0]  re_pipe;
    always @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) re_pipe <= 2'b00;
        else            re_pipe <= {re_pipe[0], bif.bus_re};
    always @(posedge sys_clk) if (bif.bus_we) mem[bif.bus_addr] <= bif.bus_wdata;
    assign bif.bus_rvalid = re_pipe[1] & bank_en;
    assign bif.bus_rdata  = bank_mem ? mem[bif.bus_addr] : bank_data;

    // Strobe monitor
    int          we_cnt = 0, re_cnt = 0;
    logic [6:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    always @(posedge sys_clk) begin
        if (bif.bus_we) begin
            we_cnt  <= we_cnt + 1;
            wr_addr <= bif.bus_addr;
            wr_data <= bif.bus_wdata;
        end
        if (bif.bus_re) begin
            re_cnt  <= re_cnt + 1;
            rd_addr <= bif.bus_addr;
        end
    end

    int checks = 0, errors = 0;
    int we0, re0, rst_we, rst_re, exp_err;
    logic [15:0] rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host frame. ndata < 16 aborts early; rst_bit >= 0 pulses sys_rst_n
    // around that SPI clock; oe_chk samples spi_miso_oe 10 ns after cs_n falls.
    task automatic xfer(input bit rnw, input logic [6:0] addr, input logic [15:0] wdata,
                        input int ndata, input int rst_bit, input bit oe_chk,
                        output logic [15:0] rdata);
        logic [31:0] frame;
        frame = {rnw, addr, 8'h00, (rnw ? 16'h0000 : wdata)};
        rdata = 16'h0000;
        spi_cs_n = 1'b0;
        if (oe_chk) begin
            #10 chk("oe_in_gap", {31'd0, spi_miso_oe}, 32'd0);
            #(HALF - 10);
        end else #HALF;
        for (int i = 0; i < 16 + ndata; i++) begin
            spi_mosi = frame[31 - i];
            if (i == rst_bit) begin
                sys_rst_n = 1'b0;
                rst_we = we_cnt;
                rst_re = re_cnt;
            end
            #HALF spi_clk = 1'b1;
            if (i >= 16) rdata = {rdata[14:0], spi_miso};
            #HALF spi_clk = 1'b0;
            if (i == rst_bit) sys_rst_n = 1'b1;
        end
        #HALF spi_cs_n = 1'b1;
    endtask

    initial begin
        exp_err = 0;
        #42;
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("rst_addr", {25'd0, bif.bus_addr}, 32'd0);
        chk("rst_wdata", {16'd0, bif.bus_wdata}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        #100;
        chk("idle_strobes", we_cnt + re_cnt, 32'd0);

        // 1: write 0x00 = AAAA
        we0 = we_cnt; re0 = re_cnt;
        xfer(1'b0, 7'h00, 16'hAAAA, 16, -1, 1'b0, rx);
        #100;
        chk("t1_we_count", we_cnt - we0, 32'd1);
        chk("t1_re_count", re_cnt - re0, 32'd0);
        chk("t1_addr", {25'd0, wr_addr}, 32'h00);
        chk("t1_wdata", {16'd0, wr_data}, 32'hAAAA);

        // 2: reads of 0x00 with several bank patterns
        bank_data = 16'h2A2A; re0 = re_cnt;
        xfer(1'b1, 7'h00, 16'h0, 16, -1, 1'b0, rx); #100;
        chk("t2_rd_2A2A", {16'd0, rx}, 32'h2A2A);
        chk("t2_re_count", re_cnt - re0, 32'd1);
        chk("t2_rd_addr", {25'd0, rd_addr}, 32'h00);
        bank_data = 16'h0001;
        xfer(1'b1, 7'h00, 16'h0, 16, -1, 1'b0, rx); #100;
        chk("t2_rd_0001", {16'd0, rx}, 32'h0001);
        bank_data = 16'h8000;
        xfer(1'b1, 7'h00, 16'h0, 16, -1, 1'b0, rx); #100;
        chk("t2_rd_8000", {16'd0, rx}, 32'h8000);
        bank_data = 16'hFFFF; we0 = we_cnt;
        xfer(1'b1, 7'h00, 16'h0, 16, -1, 1'b0, rx); #100;
        chk("t2_rd_FFFF", {16'd0, rx}, 32'hFFFF);
        chk("t2_no_we", we_cnt - we0, 32'd0);
        chk("t2_err", {24'd0, err_count}, 32'd0);

        // 3: late read, bank never answers
        bank_en = 1'b0;
        xfer(1'b1, 7'h05, 16'h0, 16, -1, 1'b0, rx); #100;
        bank_en = 1'b1;
        exp_err = exp_err + ERR_EN;
        chk("t3_rd_late", {16'd0, rx}, 32'h0000);
        chk("t3_err", {24'd0, err_count}, exp_err);

        // 4: aborted write after 10 data bits, then a full write
        we0 = we_cnt;
        xfer(1'b0, 7'h15, 16'h1234, 10, -1, 1'b0, rx); #100;
        exp_err = exp_err + ERR_EN;
        chk("t4_abort_no_we", we_cnt - we0, 32'd0);
        chk("t4_abort_err", {24'd0, err_count}, exp_err);
        xfer(1'b0, 7'h15, 16'h5555, 16, -1, 1'b0, rx); #100;
        chk("t4_we_count", we_cnt - we0, 32'd1);
        chk("t4_wdata", {16'd0, wr_data}, 32'h5555);
        chk("t4_addr", {25'd0, wr_addr}, 32'h15);
        chk("t4_err_hold", {24'd0, err_count}, exp_err);

        // 5: back-to-back write then read of 0x08 with a 20 ns gap
        bank_mem = 1'b1; we0 = we_cnt; re0 = re_cnt;
        xfer(1'b0, 7'h08, 16'h00FF, 16, -1, 1'b0, rx);
        #20;
        chk("t5_we_before_read", we_cnt - we0, 32'd1);
        chk("t5_re_before_read", re_cnt - re0, 32'd0);
        xfer(1'b1, 7'h08, 16'h0, 16, -1, 1'b1, rx); #100;
        chk("t5_re_count", re_cnt - re0, 32'd1);
        chk("t5_we_count", we_cnt - we0, 32'd1);
        chk("t5_readback", {16'd0, rx}, 32'h00FF);

        // 6: reset during the dummy phase of a read, then a normal frame pair
        xfer(1'b1, 7'h08, 16'h0, 16, 10, 1'b0, rx); #100;
        exp_err = 0;
        chk("t6_no_we", we_cnt - rst_we, 32'd0);
        chk("t6_no_re", re_cnt - rst_re, 32'd0);
        chk("t6_rx_zero", {16'd0, rx}, 32'h0000);
        chk("t6_miso", {31'd0, spi_miso}, 32'd0);
        chk("t6_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("t6_addr", {25'd0, bif.bus_addr}, 32'd0);
        chk("t6_wdata", {16'd0, bif.bus_wdata}, 32'd0);
        chk("t6_err", {24'd0, err_count}, exp_err);
        we0 = we_cnt; re0 = re_cnt;
        xfer(1'b0, 7'h22, 16'h1234, 16, -1, 1'b0, rx); #100;
        xfer(1'b1, 7'h22, 16'h0, 16, -1, 1'b0, rx); #100;
        chk("t6_post_we", we_cnt - we0, 32'd1);
        chk("t6_post_re", re_cnt - re0, 32'd1);
        chk("t6_post_addr", {25'd0, rd_addr}, 32'h22);
        chk("t6_post_rd", {16'd0, rx}, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
